axis_mem_sink: RTL and testbench

- AXI4-Stream slave that captures one packet of incoming beats into an internal word memory.
- It is the receive-side counterpart of the memory-to-stream master in main_wrapper. It consumes a stream like m03_axis_* and stores it for read-back and comparison.
- It exposes a synchronous read port plus status (word count, packet done, overflow) so loopback benches can check the transmitter end-to-end.

---
 rtl/axis_mem_sink_pkg.sv | 18 +
 rtl/axis_mem_sink_bram.sv | 45 ++++
 rtl/axis_mem_sink.sv | 136 +++++++++++++
 tb/tb_axis_mem_sink.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_mem_sink_pkg.sv
// Shared definitions for the AXI4-Stream capture sink: FSM encoding and
// strobe-width helper.
package axis_mem_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_mem_sink_bram.sv
// Capture memory: single clock, byte-enable write port, registered read port.
// Contents are never reset; only the read register is.
module axis_sink_bram
  import axis_mem_sink_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  localparam int SW = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Byte-masked write; unstrobed lanes keep their previous contents.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < SW; b++) begin
      if (wr_en_i && wr_strb_i[b]) begin
        mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Read-before-write: a same-address write this cycle is not visible yet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_mem_sink.sv
// AXI4-Stream slave that captures one packet into an internal word memory
// and reports word count, packet-done and overflow for loopback checking.
module axis_mem_sink
  import axis_mem_sink_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s04_axis_aclk,
  input  logic                    s04_axis_areset,
  input  logic                    s04_axis_enable,
  input  logic [DATA_WIDTH-1:0]   s04_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s04_axis_tstrb,
  input  logic                    s04_axis_tvalid,
  input  logic                    s04_axis_tlast,
  output logic                    s04_axis_tready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic                    pkt_done,
  output logic                    overflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic                  tready_q, tready_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  overflow_q, overflow_d;

  logic                  accept_s;
  logic [ADDR_WIDTH:0]   count_inc_s;

  assign accept_s    = s04_axis_tvalid & tready_q & (state_q == ST_RECV);
  assign count_inc_s = word_count_q + CNT_ONE;

  // Next-state and next-status logic; tready is computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    tready_d     = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    word_count_d = word_count_q;
    pkt_done_d   = pkt_done_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (s04_axis_enable) begin
          state_d      = ST_RECV;
          tready_d     = 1'b1;
          wr_ptr_d     = '0;
          word_count_d = '0;
          pkt_done_d   = 1'b0;
          overflow_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (accept_s) begin
          wr_ptr_d     = wr_ptr_q + PTR_ONE;
          word_count_d = count_inc_s;
        end else begin
          wr_ptr_d     = wr_ptr_q;
        end
        // tlast outranks the full check so a packet ending on the final slot is clean.
        if (accept_s && s04_axis_tlast) begin
          state_d    = ST_DONE;
          pkt_done_d = 1'b1;
        end else if (accept_s && (count_inc_s == FULL_COUNT)) begin
          state_d    = ST_DONE;
          overflow_d = 1'b1;
        end else if (!s04_axis_enable) begin
          state_d = ST_IDLE;
        end else begin
          tready_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!s04_axis_enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tready_d = 1'b0;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge s04_axis_aclk or posedge s04_axis_areset) begin
    if (s04_axis_areset) begin
      state_q      <= ST_IDLE;
      tready_q     <= 1'b0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      pkt_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
      pkt_done_q   <= pkt_done_d;
      overflow_q   <= overflow_d;
    end
  end

  axis_sink_bram #(
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk_i     (s04_axis_aclk),
    .rst_i     (s04_axis_areset),
    .wr_en_i   (accept_s),
    .wr_addr_i (wr_ptr_q),
    .wr_strb_i (s04_axis_tstrb),
    .wr_data_i (s04_axis_tdata),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign s04_axis_tready = tready_q;
  assign word_count      = word_count_q;
  assign pkt_done        = pkt_done_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_axis_mem_sink.sv
// Directed bench for axis_mem_sink with an 8-word memory so the overflow and
// final-slot cases are reachable quickly.
module tb_axis_mem_sink;

  localparam int MS = 8;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [DW-1:0] tdata;
  logic [3:0]    tstrb;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   word_count;
  logic          pkt_done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  axis_mem_sink #(.MEM_SIZE(MS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .s04_axis_aclk   (clk),
    .s04_axis_areset (rst),
    .s04_axis_enable (enable),
    .s04_axis_tdata  (tdata),
    .s04_axis_tstrb  (tstrb),
    .s04_axis_tvalid (tvalid),
    .s04_axis_tlast  (tlast),
    .s04_axis_tready (tready),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .word_count      (word_count),
    .pkt_done        (pkt_done),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat at a negedge and hold it until a handshake edge has passed.
  task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit ok;
    ok = 1'b0;
    tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (tready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("handshake", 64'(ok), 64'd1);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk("rd_data", 64'(rd_data), 64'(exp));
  endtask

  task automatic rearm();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0;
    tlast = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;

    // Reset asserted mid-RECV acts without a clock edge.
    enable = 1'b1;
    @(negedge clk);
    chk("enter_tready", 64'(tready), 64'd1);
    send(32'h0A0A0A00, 4'hF, 1'b0);
    send(32'h0A0A0A01, 4'hF, 1'b0);
    chk("t1_wc_pre", 64'(word_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_tready", 64'(tready), 64'd0);
    chk("t1_async_wc", 64'(word_count), 64'd0);
    chk("t1_async_pkt_done", 64'(pkt_done), 64'd0);
    chk("t1_async_overflow", 64'(overflow), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_idle_tready", 64'(tready), 64'd0);

    // Basic 4-beat packet.
    enable = 1'b1;
    @(negedge clk);
    send(32'h11111111, 4'hF, 1'b0);
    send(32'h22222222, 4'hF, 1'b0);
    send(32'h33333333, 4'hF, 1'b0);
    send(32'h44444444, 4'hF, 1'b1);
    chk("t2_wc", 64'(word_count), 64'd4);
    chk("t2_pkt_done", 64'(pkt_done), 64'd1);
    chk("t2_tready", 64'(tready), 64'd0);
    chk("t2_overflow", 64'(overflow), 64'd0);
    tvalid = 1'b1; tdata = 32'hDEADBEEF; tstrb = 4'hF;
    repeat (2) @(negedge clk);
    tvalid = 1'b0;
    chk("t2_done_backpressure_wc", 64'(word_count), 64'd4);
    rd(3'd2, 32'h33333333);
    rd(3'd0, 32'h11111111);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_idle_pkt_done_held", 64'(pkt_done), 64'd1);
    chk("t2_idle_wc_held", 64'(word_count), 64'd4);

    // Gapped valid.
    enable = 1'b1;
    @(negedge clk);
    chk("t3_wc_cleared", 64'(word_count), 64'd0);
    chk("t3_pkt_done_cleared", 64'(pkt_done), 64'd0);
    send(32'h55555555, 4'hF, 1'b0);
    @(negedge clk);
    chk("t3_wc_gap", 64'(word_count), 64'd1);
    send(32'h66666666, 4'hF, 1'b0);
    @(negedge clk);
    send(32'h77777777, 4'hF, 1'b0);
    @(negedge clk);
    send(32'h88888888, 4'hF, 1'b1);
    @(negedge clk);
    chk("t3_wc", 64'(word_count), 64'd4);
    chk("t3_pkt_done", 64'(pkt_done), 64'd1);
    rd(3'd0, 32'h55555555);
    rd(3'd1, 32'h66666666);
    rd(3'd3, 32'h88888888);

    // Partial strobe merge into address 0.
    rearm();
    send(32'hAABBCCDD, 4'hF, 1'b1);
    rd(3'd0, 32'hAABBCCDD);
    rearm();
    send(32'h11223344, 4'h5, 1'b1);
    rd(3'd0, 32'hAA22CC44);
    chk("t4_wc", 64'(word_count), 64'd1);

    // Overflow: 10 beats offered, no tlast.
    rearm();
    for (int i = 0; i < 10; i++) begin
      tvalid = 1'b1; tstrb = 4'hF; tlast = 1'b0; tdata = 32'hC0 + 32'(i);
      @(negedge clk);
    end
    tvalid = 1'b0;
    chk("t5_wc", 64'(word_count), 64'd8);
    chk("t5_overflow", 64'(overflow), 64'd1);
    chk("t5_pkt_done", 64'(pkt_done), 64'd0);
    chk("t5_tready", 64'(tready), 64'd0);
    repeat (2) @(negedge clk);
    chk("t5_tready_held", 64'(tready), 64'd0);
    rd(3'd0, 32'h000000C0);
    rd(3'd7, 32'h000000C7);

    // tlast on the final slot is a clean packet, not an overflow.
    rearm();
    for (int i = 0; i < 8; i++) begin
      send(32'hE0 + 32'(i), 4'hF, (i == 7));
    end
    chk("t5b_wc", 64'(word_count), 64'd8);
    chk("t5b_pkt_done", 64'(pkt_done), 64'd1);
    chk("t5b_overflow", 64'(overflow), 64'd0);

    // Enable dropped after two beats.
    rearm();
    send(32'hD0D0D0D0, 4'hF, 1'b0);
    send(32'hD1D1D1D1, 4'hF, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("t6_tready", 64'(tready), 64'd0);
    chk("t6_wc", 64'(word_count), 64'd2);
    chk("t6_pkt_done", 64'(pkt_done), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    tvalid = 1'b1; tdata = 32'hD2D2D2D2; tstrb = 4'hF;
    repeat (3) @(negedge clk);
    tvalid = 1'b0;
    chk("t6_wc_after", 64'(word_count), 64'd2);
    rd(3'd1, 32'hD1D1D1D1);
    rd(3'd2, 32'h000000E2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
